axis_dw_down: RTL
=================

# axis_dw_down

Single-clock AXI-Stream downsizer. It takes one wide beat of `DATA_WIDTH_IN` bits and emits it as `RATIO = DATA_WIDTH_IN/DATA_WIDTH_OUT` narrow beats, lowest lane first, using `tkeep` to trim unused upper lanes. It sits on the transmit side of a datapath, after wide internal processing, to feed a narrow serial or PHY-facing stream, mirroring the narrow-to-wide packing done on the receive side.

## Interface
- `DATA_WIDTH_IN`, 128, wide input data width; must be a multiple of `DATA_WIDTH_OUT`.
- `DATA_WIDTH_OUT`, 32, narrow output data width; must be a multiple of 8.
- `TLAST_EN`, 0, 1 = propagate `tlast`; 0 = `m_axis_tlast_o` tied 0.
- `KEEP_EN`, 1, 1 = trim lanes using `tkeep`; 0 = always emit all `RATIO` lanes, output keep all-ones.
- `clk_i`  in  1  clock; the block uses this single clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `s_axis_tdata_i`  in  `DATA_WIDTH_IN`  wide input data.
- `s_axis_tkeep_i`  in  `DATA_WIDTH_IN/8`  input byte enables.
- `s_axis_tlast_i`  in  1  end of packet.
- `s_axis_tvalid_i`  in  1  input valid.
- `s_axis_tready_o`  out  1  input ready.
- `m_axis_tdata_o`  out  `DATA_WIDTH_OUT`  narrow output data.
- `m_axis_tkeep_o`  out  `DATA_WIDTH_OUT/8`  output byte enables.
- `m_axis_tlast_o`  out  1  end of packet.
- `m_axis_tvalid_o`  out  1  output valid.
- `m_axis_tready_i`  in  1  output ready.

## Operation
- Lane i: data `[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT]`, keep `[i*DATA_WIDTH_OUT/8 +: DATA_WIDTH_OUT/8]`.
- On input handshake, latch data, keep and last into holding registers. Set `lane_cnt = 0` and `lane_max` as follows:
  - `KEEP_EN = 1`: index of the highest lane with nonzero keep. All-zero keep gives `lane_max = 0`.
  - `KEEP_EN = 0`: `RATIO-1`.
- Lanes below `lane_max` are always emitted, including interior zero-keep lanes, with their keep as received.
- Null beat (all-zero keep) emits exactly one output beat: lane 0, keep 0, `tlast` = input `tlast`.
- `m_axis_tlast_o` = `last_q & (lane_cnt == lane_max)` when `TLAST_EN = 1`.
- There are two states:
  - IDLE: `busy = 0`.
  - SEND: `busy = 1`. On each output handshake, `lane_cnt` increments.
  - At `lane_cnt == lane_max` with an output handshake, go to SEND again if a new input is accepted in the same cycle, otherwise IDLE.
- `s_axis_tready_o = ~rst_i & (~busy | (m_axis_tready_i & lane_cnt == lane_max))`. This is a combinational ready path, which is permitted.
- `m_axis_tvalid_o = busy`. Data and keep are muxed from registered state only; there is no path from `s_axis_*` to `m_axis_*`.
- `RATIO = 1` degenerates to a one-stage register slice.
- Elaboration `$error` if `DATA_WIDTH_IN % DATA_WIDTH_OUT != 0`, `DATA_WIDTH_OUT % 8 != 0`, or `DATA_WIDTH_IN < DATA_WIDTH_OUT`.

## Timing
- Reset values: `busy`, `lane_cnt`, `m_axis_tvalid_o`, `m_axis_tlast_o` and `m_axis_tdata_o`/`m_axis_tkeep_o` (holding registers cleared) are all 0. `s_axis_tready_o` is 0 while `rst_i` is high and 1 on the first cycle after release.
- Latency: input handshake at cycle N gives the first output beat valid at N+1.
- Throughput: one output beat per cycle with no bubbles between consecutive wide beats. With continuous traffic and `m_axis_tready_i = 1`, `s_axis_tready_o` is high one cycle in every `lane_max+1`.
- Output stability: while `m_axis_tvalid_o & ~m_axis_tready_i`, all `m_axis_*` signals hold stable.
- Reset mid-packet: the next cycle shows `m_axis_tvalid_o = 0` and the held beat is discarded. The first beat after release starts at lane 0.

## Structure
- Shared package `axis_dw_pkg`:
  - `RATIO` and lane-width localparam derivation functions.
  - Function `msb_lane(keep)` returning the highest nonzero lane index, shared with the upsizer.
- Counter, lane mux and handshake logic live in `axis_dw_down`. No sub-module.

## Test plan
- Full beat, 128→32, `KEEP_EN = 1`, `TLAST_EN = 1`: data `0x44444444_33333333_22222222_11111111`, keep `0xFFFF`, `tlast = 1`. Expect `11111111`, `22222222`, `33333333`, `44444444`, keep `0xF` each, `tlast` on the 4th only.
- Partial keep: keep `0x00FF`, `tlast = 1`. Expect 2 beats `11111111`, `22222222`, `tlast` on the 2nd. Keep `0x003F` gives 2 beats, second keep `0x3`.
- Null beat: keep `0x0000`, `tlast = 1`. Expect exactly one beat with keep 0 and `tlast = 1`.
- Back-to-back: 16 consecutive wide beats, `m_axis_tready_i = 1`. Expect `m_axis_tvalid_o` continuous for 64 cycles and `s_axis_tready_o` pattern `1000` repeating.
- Random backpressure: 50% `m_axis_tready_i`, 50% `s_axis_tvalid_i`, 1000 random beats with random keep and last. Scoreboard requires exact lane order, no loss or duplication, and outputs held stable while stalled.
- Reset mid-packet: assert `rst_i` for 1 cycle while lane 2 is presented. Expect `m_axis_tvalid_o = 0` the next cycle; the next input beat is output starting at lane 0.

Source files
------------

// File: rtl/axis_dw_pkg.sv
// Shared helpers for the AXI-Stream width converters: lane geometry and
// highest-active-lane search over a byte-enable vector.
package axis_dw_pkg;

  // Widest keep vector the lane search handles (512-bit data).
  localparam int KEEP_MAX_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } dw_state_t;

  function automatic int calc_ratio(input int w_wide, input int w_narrow);
    return (w_narrow > 0) ? (w_wide / w_narrow) : 1;
  endfunction

  function automatic int lane_bytes(input int w_narrow);
    return w_narrow / 8;
  endfunction

  function automatic int cnt_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Walks the keep vector one lane at a time; the last lane with any byte set wins.
  function automatic int msb_lane(input logic [KEEP_MAX_W-1:0] keep,
                                  input int lane_bytes_n);
    logic [KEEP_MAX_W-1:0] rest;
    logic [KEEP_MAX_W-1:0] mask;
    int lane;
    lane = 0;
    rest = keep;
    mask = ~({KEEP_MAX_W{1'b1}} << lane_bytes_n);
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      if ((rest & mask) != '0) lane = i;
      rest = rest >> lane_bytes_n;
    end
    return lane;
  endfunction

endpackage

// File: rtl/axis_dw_down.sv
// AXI-Stream downsizer: one wide beat in, up to RATIO narrow beats out,
// lowest lane first, trailing empty lanes trimmed by tkeep.
module axis_dw_down
  import axis_dw_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 128,
  parameter int DATA_WIDTH_OUT = 32,
  parameter int TLAST_EN       = 0,
  parameter int KEEP_EN        = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [DATA_WIDTH_IN-1:0]    s_axis_tdata_i,
  input  logic [DATA_WIDTH_IN/8-1:0]  s_axis_tkeep_i,
  input  logic                        s_axis_tlast_i,
  input  logic                        s_axis_tvalid_i,
  output logic                        s_axis_tready_o,
  output logic [DATA_WIDTH_OUT-1:0]   m_axis_tdata_o,
  output logic [DATA_WIDTH_OUT/8-1:0] m_axis_tkeep_o,
  output logic                        m_axis_tlast_o,
  output logic                        m_axis_tvalid_o,
  input  logic                        m_axis_tready_i
);

  localparam int RATIO      = calc_ratio(DATA_WIDTH_IN, DATA_WIDTH_OUT);
  localparam int LANE_BYTES = lane_bytes(DATA_WIDTH_OUT);
  localparam int KEEP_IN_W  = DATA_WIDTH_IN / 8;
  localparam int CNT_W      = cnt_width(RATIO);
  localparam int LANE_SLOTS = 2 ** CNT_W;

  if ((DATA_WIDTH_IN % DATA_WIDTH_OUT) != 0) begin : g_err_multiple
    $error("axis_dw_down: DATA_WIDTH_IN must be a multiple of DATA_WIDTH_OUT");
  end
  if ((DATA_WIDTH_OUT % 8) != 0) begin : g_err_bytes
    $error("axis_dw_down: DATA_WIDTH_OUT must be a multiple of 8");
  end
  if (DATA_WIDTH_IN < DATA_WIDTH_OUT) begin : g_err_order
    $error("axis_dw_down: DATA_WIDTH_IN must not be smaller than DATA_WIDTH_OUT");
  end
  if (KEEP_IN_W > KEEP_MAX_W) begin : g_err_keep
    $error("axis_dw_down: input keep wider than the lane search supports");
  end

  dw_state_t                state_q, state_d;
  logic [CNT_W-1:0]         lane_cnt, lane_cnt_d;
  logic [CNT_W-1:0]         lane_max, lane_max_in;
  logic [DATA_WIDTH_IN-1:0] data_q;
  logic [KEEP_IN_W-1:0]     keep_q;
  logic                     last_q;
  logic                     busy, at_last, in_hs, out_hs;

  logic [DATA_WIDTH_OUT-1:0] data_lanes [LANE_SLOTS];
  logic [LANE_BYTES-1:0]     keep_lanes [LANE_SLOTS];

  // Counter slots past RATIO only exist to keep the index width exact.
  for (genvar g = 0; g < LANE_SLOTS; g++) begin : g_lane
    if (g < RATIO) begin : g_used
      assign data_lanes[g] = data_q[g*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
      assign keep_lanes[g] = keep_q[g*LANE_BYTES +: LANE_BYTES];
    end else begin : g_unused
      assign data_lanes[g] = '0;
      assign keep_lanes[g] = '0;
    end
  end

  always_comb begin
    busy            = (state_q == SEND);
    at_last         = (lane_cnt == lane_max);
    s_axis_tready_o = ~rst_i & (~busy | (m_axis_tready_i & at_last));
    in_hs           = s_axis_tvalid_i & s_axis_tready_o;
    out_hs          = busy & m_axis_tready_i;
    lane_max_in     = (KEEP_EN != 0)
                      ? CNT_W'(msb_lane(KEEP_MAX_W'(s_axis_tkeep_i), LANE_BYTES))
                      : CNT_W'(RATIO - 1);
  end

  // A new wide beat always restarts at lane 0, even when it lands on the
  // final lane handshake of the previous one.
  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt;
    if (in_hs) begin
      state_d    = SEND;
      lane_cnt_d = '0;
    end else if (out_hs) begin
      if (at_last) begin
        state_d    = IDLE;
        lane_cnt_d = '0;
      end else begin
        lane_cnt_d = lane_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      lane_cnt <= '0;
      lane_max <= '0;
      data_q   <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lane_cnt <= lane_cnt_d;
      if (in_hs) begin
        data_q   <= s_axis_tdata_i;
        keep_q   <= (KEEP_EN != 0) ? s_axis_tkeep_i : {KEEP_IN_W{1'b1}};
        last_q   <= (TLAST_EN != 0) ? s_axis_tlast_i : 1'b0;
        lane_max <= lane_max_in;
      end
    end
  end

  always_comb begin
    m_axis_tvalid_o = busy;
    m_axis_tdata_o  = data_lanes[lane_cnt];
    m_axis_tkeep_o  = keep_lanes[lane_cnt];
    m_axis_tlast_o  = last_q & at_last;
  end

endmodule
